// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator chain and its compensation FIR.
//   clog2   : ceiling log2 used for pointer, counter and accumulator sizing.
//   acc_dw  : accumulator width that rules out overflow in the compensator.
//   comp_state_t : sequencing states of the time-multiplexed compensator.
package cic_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // One extra bit for the pre-add, plus growth from summing H products.
    function automatic int acc_dw(input int inp_dw, input int coef_dw, input int n_taps);
        return inp_dw + 1 + coef_dw + clog2((n_taps + 1) / 2);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } comp_state_t;

endpackage

// File: rtl/round_sat.sv
// Combinational round-half-up (toward +inf) and saturate.
//   din_i  : signed IN_DW value to be scaled down by 2^SHIFT.
//   dout_o : signed OUT_DW result, clamped to the representable range.
// Requires IN_DW >= OUT_DW and SHIFT >= 1.
module round_sat #(
    parameter int IN_DW  = 40,
    parameter int OUT_DW = 18,
    parameter int SHIFT  = 15
) (
    input  logic signed [IN_DW-1:0]  din_i,
    output logic signed [OUT_DW-1:0] dout_o
);

    localparam logic [IN_DW:0] RND = (IN_DW + 1)'(1) << (SHIFT - 1);
    localparam logic signed [OUT_DW-1:0] OMAX = {1'b0, {(OUT_DW - 1){1'b1}}};
    localparam logic signed [OUT_DW-1:0] OMIN = {1'b1, {(OUT_DW - 1){1'b0}}};

    logic signed [IN_DW:0] sum;
    logic signed [IN_DW:0] shr;
    logic [IN_DW-OUT_DW+1:0] hi;

    always_comb begin
        // One guard bit so adding the rounding constant can never wrap.
        sum = (IN_DW + 1)'(din_i) + $signed(RND);
        shr = sum >>> SHIFT;
        // Result fits only when every bit above the output MSB matches it.
        hi  = shr[IN_DW:OUT_DW-1];
        if (&hi || ~|hi) begin
            dout_o = shr[OUT_DW-1:0];
        end else begin
            dout_o = shr[IN_DW] ? OMIN : OMAX;
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// Symmetric CIC droop-compensation FIR, time-multiplexed over one
// pre-adder / multiplier / accumulator.
//   clk, reset        : sole clock, synchronous active-high reset.
//   s_axis_in_tdata   : signed input sample (decimated CIC output).
//   s_axis_in_tvalid  : input strobe; no backpressure.
//   m_axis_out_tdata  : rounded, saturated output; holds between strobes.
//   m_axis_out_tvalid : single-cycle output strobe, H+2 cycles after input.
//   overrun           : single-cycle pulse for an input dropped while busy.
module cic_comp_fir
    import cic_pkg::*;
#(
    parameter int INP_DW  = 18,
    parameter int OUT_DW  = 18,
    parameter int COEF_DW = 18,
    parameter int N_TAPS  = 15,
    parameter logic [COEF_DW*((N_TAPS+1)/2)-1:0] COEFS = '0,
    parameter int SHIFT   = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [INP_DW-1:0] s_axis_in_tdata,
    input  logic                     s_axis_in_tvalid,
    output logic signed [OUT_DW-1:0] m_axis_out_tdata,
    output logic                     m_axis_out_tvalid,
    output logic                     overrun
);

    localparam int H      = (N_TAPS + 1) / 2;
    localparam int ACC_W  = acc_dw(INP_DW, COEF_DW, N_TAPS);
    localparam int PW     = clog2(N_TAPS);
    localparam int KW     = clog2(H);
    localparam int PRE_W  = INP_DW + 1;
    localparam int PROD_W = PRE_W + COEF_DW;

    comp_state_t              state_q, state_d;
    logic [PW-1:0]            wp_q, wp_d;
    logic [KW-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [INP_DW-1:0] dline_q [N_TAPS];
    logic signed [OUT_DW-1:0] tdata_q, tdata_d;
    logic                     tvalid_q, tvalid_d;
    logic                     ovr_q, ovr_d;

    logic                     accept;
    logic [PW:0]              ia_sum, ib_sum;
    logic [PW-1:0]            ia, ib;
    logic signed [INP_DW-1:0] xa, xb;
    logic signed [PRE_W-1:0]  pre;
    logic signed [COEF_DW-1:0] coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_DW-1:0] y;

    assign accept = (state_q == IDLE) && s_axis_in_tvalid;

    // wp already points past the newest sample during MAC, so
    // x[k] lives at (wp-1-k) mod N and its mirror x[N-1-k] at (wp+k) mod N.
    always_comb begin
        ia_sum = (PW + 1)'(wp_q) + (PW + 1)'(N_TAPS - 1) - (PW + 1)'(k_q);
        ib_sum = (PW + 1)'(wp_q) + (PW + 1)'(k_q);
        if (ia_sum >= (PW + 1)'(N_TAPS)) ia_sum = ia_sum - (PW + 1)'(N_TAPS);
        if (ib_sum >= (PW + 1)'(N_TAPS)) ib_sum = ib_sum - (PW + 1)'(N_TAPS);
        ia = ia_sum[PW-1:0];
        ib = ib_sum[PW-1:0];
    end

    assign xa   = dline_q[ia];
    assign xb   = dline_q[ib];
    // The centre tap has no mirror partner, so it skips the pre-add.
    assign pre  = (k_q == KW'(H - 1)) ? PRE_W'(xa) : PRE_W'(xa) + PRE_W'(xb);
    assign coef = $signed(COEFS[COEF_DW*int'(k_q) +: COEF_DW]);
    assign prod = PROD_W'(pre) * PROD_W'(coef);

    round_sat #(
        .IN_DW (ACC_W),
        .OUT_DW(OUT_DW),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .din_i (acc_q),
        .dout_o(y)
    );

    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        k_d      = k_q;
        acc_d    = acc_q;
        tdata_d  = tdata_q;
        tvalid_d = 1'b0;
        ovr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_axis_in_tvalid) begin
                    wp_d    = (wp_q == PW'(N_TAPS - 1)) ? '0 : wp_q + PW'(1);
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                ovr_d = s_axis_in_tvalid;
                if (k_q == KW'(H - 1)) begin
                    state_d = ROUND;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ROUND: begin
                tdata_d  = y;
                tvalid_d = 1'b1;
                ovr_d    = s_axis_in_tvalid;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wp_q     <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    // History is cleared on reset so a fresh stream sees no stale samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) begin
                dline_q[i] <= '0;
            end
        end else if (accept) begin
            dline_q[wp_q] <= s_axis_in_tdata;
        end
    end

    assign m_axis_out_tdata  = tdata_q;
    assign m_axis_out_tvalid = tvalid_q;
    assign overrun           = ovr_q;

endmodule
